// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: stall bit indices,
// controller states and the trap/mret fetch target selection.
package pipe_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  localparam int STALL_W   = STALL_WB + 1;

  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;
  localparam logic        RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef logic [STALL_W-1:0] stall_vec_t;

  typedef enum logic {
    PCTRL_RUN   = 1'b0,
    PCTRL_FLUSH = 1'b1
  } pctrl_state_e;

  // A trap goes to mtvec; a lone mret returns to mepc.
  function automatic logic [31:0] flush_target(input logic        is_trap,
                                               input logic [31:0] tvec,
                                               input logic [31:0] mepc);
    return is_trap ? tvec : mepc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages (master) and the
// pipeline controller (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic             stallreq_id_i;
  logic             stallreq_ex_i;
  logic             stallreq_mem_i;
  logic [31:0]      exception_i;
  logic             mret_i;
  logic [31:0]      trap_vector_i;
  logic [31:0]      mepc_i;
  logic             branch_redirect_i;
  logic [31:0]      branch_target_i;

  stall_vec_t       stall_o;
  logic             flush_o;
  logic [31:0]      new_pc_o;
  logic             redirect_o;
  logic             trap_taken_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output stallreq_id_i, stallreq_ex_i, stallreq_mem_i, exception_i, mret_i,
           trap_vector_i, mepc_i, branch_redirect_i, branch_target_i,
    input  stall_o, flush_o, new_pc_o, redirect_o, trap_taken_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_id_i, stallreq_ex_i, stallreq_mem_i, exception_i, mret_i,
           trap_vector_i, mepc_i, branch_redirect_i, branch_target_i,
    output stall_o, flush_o, new_pc_o, redirect_o, trap_taken_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_stall_merge.sv
// Merges the stage stall requests into the per-register stall vector; a request
// from a stage freezes that stage and everything upstream of it.
module pipe_ctrl_stall_merge
  import pipe_ctrl_pkg::*;
(
  input  logic       stallreq_id,
  input  logic       stallreq_ex,
  input  logic       stallreq_mem,
  output stall_vec_t stall
);

  genvar gi;
  generate
    for (gi = STALL_PC; gi <= STALL_WB; gi++) begin : g_bit
      localparam bit COVER_ID  = (gi <= STALL_ID);
      localparam bit COVER_EX  = (gi <= STALL_EX);
      localparam bit COVER_MEM = (gi <= STALL_MEM);

      assign stall[gi] = ((stallreq_mem && COVER_MEM) ||
                          (stallreq_ex  && COVER_EX)  ||
                          (stallreq_id  && COVER_ID)) ? STOP : NO_STOP;
    end
  endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector, one-cycle trap/mret flush with new fetch PC,
// deferred branch redirects while fetch is frozen, and a saturating stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk_i,
  input logic        n_rst_i,
  pipe_ctrl_if.slave bus
);

  pctrl_state_e     state_reg;
  logic             flush_reg;
  logic             trap_taken_reg;
  logic             pend_v_reg;
  logic [31:0]      pend_pc_reg;
  logic [31:0]      new_pc_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  stall_vec_t       stall_req;
  stall_vec_t       stall_vec;
  logic             in_run;
  logic             exc_req;
  logic             trap_req;
  logic             fetch_free;
  logic             redirect;
  logic [31:0]      redirect_pc;

  pipe_ctrl_stall_merge u_stall_merge (
    .stallreq_id  (bus.stallreq_id_i),
    .stallreq_ex  (bus.stallreq_ex_i),
    .stallreq_mem (bus.stallreq_mem_i),
    .stall        (stall_req)
  );

  // Nothing is stalled or redirected while in reset or during the flush cycle.
  assign in_run     = (n_rst_i != RST_ENABLE) && (state_reg == PCTRL_RUN);
  assign stall_vec  = in_run ? stall_req : '0;
  assign exc_req    = (bus.exception_i != ZERO_WORD);
  assign trap_req   = in_run && (exc_req || bus.mret_i) && !bus.stallreq_mem_i;
  assign fetch_free = (stall_vec[STALL_IF] == NO_STOP);

  // A fresh branch takes precedence over (and discards) an older pending target.
  assign redirect    = in_run && !trap_req && fetch_free &&
                       (bus.branch_redirect_i || pend_v_reg);
  assign redirect_pc = bus.branch_redirect_i ? bus.branch_target_i : pend_pc_reg;

  assign bus.stall_o      = stall_vec;
  assign bus.flush_o      = flush_reg;
  assign bus.trap_taken_o = trap_taken_reg;
  assign bus.redirect_o   = redirect;
  assign bus.new_pc_o     = redirect ? redirect_pc : new_pc_reg;
  assign bus.stall_cnt_o  = stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (n_rst_i == RST_ENABLE) begin
      state_reg      <= PCTRL_RUN;
      flush_reg      <= 1'b0;
      trap_taken_reg <= 1'b0;
      pend_v_reg     <= 1'b0;
      pend_pc_reg    <= ZERO_WORD;
      new_pc_reg     <= RESET_PC;
      stall_cnt_reg  <= '0;
    end else begin
      if ((stall_vec != '0) && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end

      case (state_reg)
        PCTRL_RUN: begin
          if (trap_req) begin
            state_reg      <= PCTRL_FLUSH;
            flush_reg      <= 1'b1;
            trap_taken_reg <= exc_req;
            new_pc_reg     <= flush_target(exc_req, bus.trap_vector_i, bus.mepc_i);
            pend_v_reg     <= 1'b0;
          end else if (redirect) begin
            // Remember the redirect so new_pc_o keeps showing it afterwards.
            new_pc_reg <= redirect_pc;
            pend_v_reg <= 1'b0;
          end else if (bus.branch_redirect_i) begin
            pend_v_reg  <= 1'b1;
            pend_pc_reg <= bus.branch_target_i;
          end
        end
        PCTRL_FLUSH: begin
          state_reg      <= PCTRL_RUN;
          flush_reg      <= 1'b0;
          trap_taken_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized check of pipe_ctrl against a behavioural model, preceded by a
// directed sequence with hand-computed expectations.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_id, req_ex, req_mem, mret, br;
  logic [31:0] exc, tvec, mepc, br_tgt;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus  ();
  pipe_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus.stallreq_id_i      = req_id;
  assign bus.stallreq_ex_i      = req_ex;
  assign bus.stallreq_mem_i     = req_mem;
  assign bus.exception_i        = exc;
  assign bus.mret_i             = mret;
  assign bus.trap_vector_i      = tvec;
  assign bus.mepc_i             = mepc;
  assign bus.branch_redirect_i  = br;
  assign bus.branch_target_i    = br_tgt;
  assign bus4.stallreq_id_i     = req_id;
  assign bus4.stallreq_ex_i     = req_ex;
  assign bus4.stallreq_mem_i    = req_mem;
  assign bus4.exception_i       = exc;
  assign bus4.mret_i            = mret;
  assign bus4.trap_vector_i     = tvec;
  assign bus4.mepc_i            = mepc;
  assign bus4.branch_redirect_i = br;
  assign bus4.branch_target_i   = br_tgt;

  pipe_ctrl #(.CNT_W(32), .RESET_PC(32'h0)) dut (
    .clk_i   (clk),
    .n_rst_i (rst_n),
    .bus     (bus)
  );

  pipe_ctrl #(.CNT_W(4), .RESET_PC(32'h0)) dut4 (
    .clk_i   (clk),
    .n_rst_i (rst_n),
    .bus     (bus4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the controller has promised so far.
  bit          m_flush;      // the next cycle is the flush cycle
  bit          m_trap;       // that flush came from an exception
  logic [31:0] m_pc;         // last fetch PC announced
  logic [31:0] m_pend[$];    // deferred branch target, at most one
  longint      m_cnt;        // stalled cycles since reset (unbounded)

  logic [5:0]  e_stall;
  bit          e_trap_now, e_redir;
  logic [31:0] e_pc;

  always @(negedge clk) begin
    if (checking) begin
      if (!rst_n) begin
        e_stall = 6'd0;
        e_redir = 1'b0;
        e_trap_now = 1'b0;
      end else begin
        if (m_flush)      e_stall = 6'd0;
        else if (req_mem) e_stall = 6'h1f;
        else if (req_ex)  e_stall = 6'h0f;
        else if (req_id)  e_stall = 6'h07;
        else              e_stall = 6'd0;
        e_trap_now = !m_flush && ((exc != 0) || mret) && !req_mem;
        e_redir = !m_flush && !e_trap_now && (e_stall == 0) &&
                  (br || (m_pend.size() != 0));
      end
      e_pc = e_redir ? (br ? br_tgt : m_pend[0]) : m_pc;

      chk("stall",       bus.stall_o,       e_stall);
      chk("flush",       bus.flush_o,       m_flush);
      chk("trap_taken",  bus.trap_taken_o,  m_flush && m_trap);
      chk("redirect",    bus.redirect_o,    e_redir);
      chk("new_pc",      bus.new_pc_o,      e_pc);
      chk("stall_cnt",   bus.stall_cnt_o,   m_cnt);
      chk("stall_cnt4",  bus4.stall_cnt_o,  (m_cnt > 15) ? 15 : m_cnt);
      chk("redirect4",   bus4.redirect_o,   e_redir);
      chk("new_pc4",     bus4.new_pc_o,     e_pc);

      // advance the model to what the coming clock edge must produce
      if (!rst_n) begin
        m_flush = 0; m_trap = 0; m_pc = 0; m_cnt = 0;
        m_pend.delete();
      end else begin
        if (e_stall != 0) m_cnt++;
        if (m_flush) begin
          m_flush = 0;
          m_trap = 0;
        end else if (e_trap_now) begin
          m_flush = 1;
          m_trap = (exc != 0);
          m_pc = (exc != 0) ? tvec : mepc;
          m_pend.delete();
        end else if (e_redir) begin
          m_pc = e_pc;
          m_pend.delete();
        end else if (br) begin
          m_pend.delete();
          m_pend.push_back(br_tgt);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_id = 0; req_ex = 0; req_mem = 0; mret = 0; br = 0;
    exc = 0; tvec = 0; mepc = 0; br_tgt = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m_flush = 0; m_trap = 0; m_pc = 0; m_cnt = 0;
    step();
    checking = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_reset_stall", bus.stall_o, 6'd0);
    chk("lit_reset_flush", bus.flush_o, 1'b0);
    chk("lit_reset_cnt",   bus.stall_cnt_o, 32'd0);
    $display("tb: reset released, outputs idle");

    step();
    for (int i = 0; i < 4; i++) begin
      req_ex = 1; req_mem = (i == 2);
      @(negedge clk);
      chk("lit_stall_vec", bus.stall_o, (i == 2) ? 6'b011111 : 6'b001111);
      step();
    end
    req_ex = 0; req_mem = 0;
    @(negedge clk);
    chk("lit_stall_cnt4", bus.stall_cnt_o, 32'd4);
    $display("tb: ex stall x4 with one mem stall, cnt=%0d", bus.stall_cnt_o);

    step();
    exc = 32'h2; tvec = 32'h8000_0100;
    @(negedge clk);
    chk("lit_trap_pre_flush", bus.flush_o, 1'b0);
    step();
    exc = 0; req_ex = 1;
    @(negedge clk);
    chk("lit_trap_flush", bus.flush_o, 1'b1);
    chk("lit_trap_taken", bus.trap_taken_o, 1'b1);
    chk("lit_trap_pc",    bus.new_pc_o, 32'h8000_0100);
    chk("lit_trap_stall", bus.stall_o, 6'd0);
    step();
    req_ex = 0;
    @(negedge clk);
    chk("lit_trap_after", bus.flush_o, 1'b0);
    $display("tb: trap to 80000100 flushed one cycle");

    step();
    br = 1; br_tgt = 32'h40; req_mem = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_br_held", bus.redirect_o, 1'b0);
      step();
      br = 0;
    end
    req_mem = 0;
    @(negedge clk);
    chk("lit_br_redir", bus.redirect_o, 1'b1);
    chk("lit_br_pc",    bus.new_pc_o, 32'h40);
    step();
    @(negedge clk);
    chk("lit_br_done",  bus.redirect_o, 1'b0);
    chk("lit_br_hold",  bus.new_pc_o, 32'h40);
    $display("tb: deferred branch to 40 released after mem stall");

    step();
    exc = 32'hB; mret = 1; br = 1; br_tgt = 32'h80;
    tvec = 32'h8000_0200; mepc = 32'h1234;
    @(negedge clk);
    chk("lit_mix_noredir", bus.redirect_o, 1'b0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("lit_mix_flush", bus.flush_o, 1'b1);
    chk("lit_mix_pc",    bus.new_pc_o, 32'h8000_0200);
    step();
    @(negedge clk);
    chk("lit_mix_nopend", bus.redirect_o, 1'b0);
    $display("tb: trap beats mret and branch");

    step();
    req_ex = 1;
    repeat (20) step();
    req_ex = 0;
    @(negedge clk);
    chk("lit_sat4", bus4.stall_cnt_o, 4'hF);
    $display("tb: 4-bit counter saturated at %0h", bus4.stall_cnt_o);

    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n   = ($urandom_range(0, 199) != 0);
      req_id  = ($urandom_range(0, 4) == 0);
      req_ex  = ($urandom_range(0, 5) == 0);
      req_mem = ($urandom_range(0, 4) == 0);
      exc     = ($urandom_range(0, 15) == 0) ? $urandom : 32'h0;
      mret    = ($urandom_range(0, 19) == 0);
      tvec    = $urandom;
      mepc    = $urandom;
      br      = ($urandom_range(0, 3) == 0);
      br_tgt  = $urandom;
    end
    @(negedge clk);
    #1;
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core (pc/if/id/ex/mem/wb). Merges stall requests from id, ex (multicycle ALU) and the lsu into the 6-bit stall vector consumed by every pipeline register. Sequences trap entry and mret as a registered one-cycle flush with a new fetch PC. Defers ex-stage branch redirects that arrive while fetch is stalled, and counts stall cycles for performance monitoring.

Parameters:
CNT_W, 32, width of stall-cycle counter (saturating)
RESET_PC, 32'h0000_0000, redirect PC reported while in reset (informational only)

Ports:
clk_i  in  1  core clock
n_rst_i  in  1  synchronous reset, active-low (`RstEnable = 1'b0)
stallreq_id_i  in  1  id load-use hazard
stallreq_ex_i  in  1  ex multicycle op busy
stallreq_mem_i  in  1  lsu waiting on bus
exception_i  in  32  exception word from mem stage; nonzero = trap
mret_i  in  1  mret retiring in mem stage
trap_vector_i  in  32  mtvec from csr unit
mepc_i  in  32  mepc from csr unit
branch_redirect_i  in  1  ex resolved taken branch/jump
branch_target_i  in  32  ex branch target
stall_o  out  6  bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = `Stop
flush_o  out  1  flush all pipeline registers
new_pc_o  out  32  fetch PC, valid with flush_o or redirect_o
redirect_o  out  1  branch redirect to fetch (no flush)
trap_taken_o  out  1  pulse, trap entered (csr unit latches mepc/mcause)
stall_cnt_o  out  CNT_W  cycles with any stall bit set

Behaviour:
- Reset (n_rst_i==0 at posedge): state=RUN, pending branch cleared, flush_o=0, trap_taken_o=0, new_pc_o=0, stall_cnt_o=0. stall_o and redirect_o are 0 during reset. Reset mid-trap or mid-pending discards everything.
- stall_o is combinational. Priority is mem > ex > id: mem req gives 6'b011111, else ex req gives 6'b001111, else id req gives 6'b000111, else 0.
- States:
  - RUN.
  - FLUSH: one cycle. flush_o=1 and new_pc_o are registered outputs of this state. stall_o is forced to 0 in FLUSH.
- RUN→FLUSH when (exception_i!=0 or mret_i) and stallreq_mem_i==0.
  - Trap: new_pc_o=trap_vector_i and trap_taken_o=1 in the FLUSH cycle.
  - mret: new_pc_o=mepc_i and trap_taken_o=0.
  - Exception beats mret if both are set.
  - FLUSH→RUN unconditionally.
- An exception while stallreq_mem_i=1 waits (held by the mem stall) until the request drops.
- Branch, in RUN with no trap this cycle:
  - If branch_redirect_i and stall_o[1]==0: redirect_o=1 and new_pc_o=branch_target_i, combinationally, same cycle.
  - If branch_redirect_i and stall_o[1]==1: latch the target into the pending register (pend_v=1). redirect_o=0.
  - While pend_v=1 and stall_o[1]==0: redirect_o=1 with new_pc_o=pend target, and pend_v clears next edge.
  - A new branch_redirect_i overwrites a pending target.
- A trap or mret entering FLUSH clears pend_v. Trap always beats branch in the same cycle.
- new_pc_o holds its last value when neither flush_o nor redirect_o is set.
- stall_cnt_o increments on every posedge where stall_o!=0 and saturates at all-ones. It is not cleared by flush.

Decomposition:
- Shared defines.v adds:
  - stall bit index constants STALL_PC..STALL_WB
  - state encodings PCTRL_RUN=1'b0, PCTRL_FLUSH=1'b1
  - existing `Stop/`NoStop/`ZeroWord/`RstEnable are reused
- The stall-vector priority encoder is natural as sub-module stall_merge (pure combinational). Everything else stays in pipe_ctrl.

Test Plan:
- Reset held 3 cycles, then release with all inputs 0 → stall_o=0, flush_o=0, stall_cnt_o=0.
- stallreq_ex_i=1 for 4 cycles → stall_o=6'b001111 for 4 cycles, stall_cnt_o=4. Adding stallreq_mem_i=1 for one of those cycles → stall_o=6'b011111 in that cycle.
- exception_i=32'h2, trap_vector_i=32'h8000_0100 → next cycle flush_o=1, trap_taken_o=1, new_pc_o=32'h8000_0100, stall_o=0. The cycle after, flush_o=0.
- branch_redirect_i=1, target 32'h0000_0040, with stallreq_mem_i=1 for 3 cycles → redirect_o=0 during the stall. redirect_o=1 with new_pc_o=32'h40 in the first unstalled cycle, then 0.
- Same cycle exception_i=32'hB, mret_i=1, branch_redirect_i=1 → flush with new_pc_o=trap_vector_i, no redirect_o, pend_v cleared.
- CNT_W=4 with a continuous stall for 20 cycles → stall_cnt_o saturates at 4'hF.
